nvram_upload: RTL and testbench

- Serves ioctl upload (core -> HPS) read requests from the game's battery/hiscore RAM. This is the reverse direction of the ROM download path (dn_addr/dn_data/dn_wr).
- Sits between hps_io ioctl upload signals and a second port of the core's NVRAM.
- Pauses the game CPU for the whole transfer so RAM contents are stable.
- Tracks a running checksum and a byte count for the OSD/status.

---
 rtl/nvram_upload.sv | 199 +++++++++++++++++++
 tb/tb_nvram_upload.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/nvram_upload.sv
// nvram_upload: serves HPS ioctl upload reads from the core's battery/hiscore
// NVRAM through a second RAM port. The game CPU is held paused for the whole
// session so the RAM contents stay stable. A running 8-bit checksum and a byte
// count of the returned in-range bytes are kept for the OSD.
module nvram_upload #(
  parameter int AW     = 10,    // NVRAM byte address width
  parameter int SIZE   = 1024,  // valid bytes, 1 <= SIZE <= 2**AW
  parameter int RD_LAT = 1      // NVRAM read latency in clk_sys cycles, 1..3
) (
  input  logic          clk_sys,
  input  logic          reset,
  input  logic          ioctl_upload,
  input  logic          ioctl_rd,
  input  logic [24:0]   ioctl_addr,
  output logic [7:0]    ioctl_din,
  output logic          ioctl_wait,
  output logic          pause_req,
  input  logic          pause_ack,
  output logic [AW-1:0] ram_addr,
  output logic          ram_rd,
  input  logic [7:0]    ram_dout,
  output logic          busy,
  output logic [7:0]    checksum,
  output logic [AW:0]   bytes_sent
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PAUSE,
    S_READY,
    S_FETCH,
    S_DONE
  } state_e;

  localparam logic [24:0] SIZE_A = 25'(SIZE);
  localparam logic [AW:0] SIZE_B = (AW+1)'(SIZE);

  state_e        state_q, state_d;
  logic          upload_q;
  logic [1:0]    cnt_q, cnt_d;
  logic [7:0]    din_q, din_d;
  logic          wait_q, wait_d;
  logic          preq_q, preq_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          rd_q, rd_d;
  logic          busy_q, busy_d;
  logic [7:0]    csum_q, csum_d;
  logic [AW:0]   bytes_q, bytes_d;

  logic up_rise, up_fall, in_range, fetch_done;

  assign up_rise    = ioctl_upload & ~upload_q;
  assign up_fall    = ~ioctl_upload & upload_q;
  assign in_range   = (ioctl_addr < SIZE_A);
  assign fetch_done = (cnt_q == 2'd0);

  // State register plus the registered copy of ioctl_upload for edge detection.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      upload_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      upload_q <= ioctl_upload;
    end
  end

  // Next-state logic; a falling upload edge aborts any active state.
  // NOTE: the default assignment first keeps this block free of latches.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (up_rise) state_d = S_PAUSE;
      S_PAUSE: begin
        if (up_fall)        state_d = S_DONE;
        else if (pause_ack) state_d = S_READY;
      end
      S_READY: begin
        if (up_fall)                   state_d = S_DONE;
        else if (ioctl_rd && in_range) state_d = S_FETCH;
      end
      S_FETCH: begin
        if (up_fall)         state_d = S_DONE;
        else if (fetch_done) state_d = S_READY;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Next values of the registered outputs; ram_rd is a one-cycle pulse.
  always_comb begin
    cnt_d   = cnt_q;
    din_d   = din_q;
    wait_d  = wait_q;
    preq_d  = preq_q;
    addr_d  = addr_q;
    rd_d    = 1'b0;
    busy_d  = busy_q;
    csum_d  = csum_q;
    bytes_d = bytes_q;
    unique case (state_q)
      S_IDLE: begin
        // A read strobe coincident with the session start is ignored.
        if (up_rise) begin
          preq_d  = 1'b1;
          busy_d  = 1'b1;
          wait_d  = 1'b1;
          csum_d  = 8'h00;
          bytes_d = '0;
        end
      end
      S_PAUSE: begin
        if (up_fall) begin
          preq_d = 1'b0;
          wait_d = 1'b0;
          busy_d = 1'b0;
        end else if (pause_ack) begin
          wait_d = 1'b0;
        end
      end
      S_READY: begin
        if (up_fall) begin
          preq_d = 1'b0;
          wait_d = 1'b0;
          busy_d = 1'b0;
        end else if (ioctl_rd) begin
          if (in_range) begin
            addr_d = ioctl_addr[AW-1:0];
            rd_d   = 1'b1;
            wait_d = 1'b1;
            cnt_d  = 2'(RD_LAT);
          end else begin
            // Out-of-range bytes read as erased flash; no RAM access.
            din_d = 8'hFF;
          end
        end
      end
      S_FETCH: begin
        if (up_fall) begin
          // The in-flight RAM result is dropped without touching the counters.
          preq_d = 1'b0;
          wait_d = 1'b0;
          busy_d = 1'b0;
        end else if (fetch_done) begin
          din_d   = ram_dout;
          csum_d  = csum_q + ram_dout;
          bytes_d = (bytes_q == SIZE_B) ? bytes_q : bytes_q + (AW+1)'(1);
          wait_d  = 1'b0;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      S_DONE: begin
        preq_d = 1'b0;
        wait_d = 1'b0;
        busy_d = 1'b0;
      end
      default: ;
    endcase
  end

  // Output registers; reset releases pause_req at once so the CPU resumes.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      cnt_q   <= 2'd0;
      din_q   <= 8'h00;
      wait_q  <= 1'b0;
      preq_q  <= 1'b0;
      addr_q  <= '0;
      rd_q    <= 1'b0;
      busy_q  <= 1'b0;
      csum_q  <= 8'h00;
      bytes_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      din_q   <= din_d;
      wait_q  <= wait_d;
      preq_q  <= preq_d;
      addr_q  <= addr_d;
      rd_q    <= rd_d;
      busy_q  <= busy_d;
      csum_q  <= csum_d;
      bytes_q <= bytes_d;
    end
  end

  assign ioctl_din  = din_q;
  assign ioctl_wait = wait_q;
  assign pause_req  = preq_q;
  assign ram_addr   = addr_q;
  assign ram_rd     = rd_q;
  assign busy       = busy_q;
  assign checksum   = csum_q;
  assign bytes_sent = bytes_q;

endmodule

// File: tb/tb_nvram_upload.sv
// Bench for nvram_upload: u_dut1 (RD_LAT=1) is checked through a scoreboard
// fed by the read driver and drained by a monitor; u_dut3 (RD_LAT=3) covers
// the abort and asynchronous reset cases with directed cycle checks.
module tb_nvram_upload;

  typedef struct packed {
    logic [7:0]  din;
    logic [7:0]  csum;
    logic [10:0] bytes;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // DUT with RD_LAT=1
  logic        reset1, upload1, rd1, ack1;
  logic [24:0] addr1;
  logic [7:0]  din1, rdout1, csum1;
  logic        wait1, preq1, rrd1, busy1;
  logic [9:0]  raddr1;
  logic [10:0] bytes1;

  // DUT with RD_LAT=3
  logic        reset3, upload3, rd3, ack3;
  logic [24:0] addr3;
  logic [7:0]  din3, rdout3, csum3;
  logic        wait3, preq3, rrd3, busy3;
  logic [9:0]  raddr3;
  logic [10:0] bytes3;

  nvram_upload #(.AW(10), .SIZE(1024), .RD_LAT(1)) u_dut1 (
    .clk_sys(clk), .reset(reset1), .ioctl_upload(upload1), .ioctl_rd(rd1),
    .ioctl_addr(addr1), .ioctl_din(din1), .ioctl_wait(wait1),
    .pause_req(preq1), .pause_ack(ack1), .ram_addr(raddr1), .ram_rd(rrd1),
    .ram_dout(rdout1), .busy(busy1), .checksum(csum1), .bytes_sent(bytes1)
  );

  nvram_upload #(.AW(10), .SIZE(1024), .RD_LAT(3)) u_dut3 (
    .clk_sys(clk), .reset(reset3), .ioctl_upload(upload3), .ioctl_rd(rd3),
    .ioctl_addr(addr3), .ioctl_din(din3), .ioctl_wait(wait3),
    .pause_req(preq3), .pause_ack(ack3), .ram_addr(raddr3), .ram_rd(rrd3),
    .ram_dout(rdout3), .busy(busy3), .checksum(csum3), .bytes_sent(bytes3)
  );

  // NVRAM model: data appears RD_LAT cycles after the ram_rd cycle.
  logic [7:0] mem [0:1023];
  logic [7:0] p3a, p3b;
  always @(posedge clk) begin
    rdout1 <= mem[raddr1];
    p3a    <= mem[raddr3];
    p3b    <= p3a;
    rdout3 <= p3b;
  end

  // RAM read pulse counters
  int nrd1 = 0, nrd3 = 0;
  always @(posedge clk) begin
    if (rrd1) nrd1 <= nrd1 + 1;
    if (rrd3) nrd3 <= nrd3 + 1;
  end

  int n_checks = 0;
  int n_pass   = 0;
  exp_t sb1[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Monitor: a read accepted with a pending expectation is sampled 2 cycles on.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      if (rd1 === 1'b1 && sb1.size() != 0) begin
        e = sb1.pop_front();
        repeat (2) @(posedge clk);
        #1;
        check("rd+2 ioctl_wait", 32'(wait1), 32'd0);
        check("ioctl_din", 32'(din1), 32'(e.din));
        check("checksum", 32'(csum1), 32'(e.csum));
        check("bytes_sent", 32'(bytes1), 32'(e.bytes));
      end
    end
  end

  // Issue one read on u_dut1 (rd held `hold` cycles), called at a negedge.
  task automatic read1(input logic [24:0] a, input exp_t e, input int hold);
    int t;
    sb1.push_back(e);
    rd1   = 1'b1;
    addr1 = a;
    repeat (hold) @(negedge clk);
    rd1 = 1'b0;
    t = 0;
    while (wait1 && t < 50) begin
      @(negedge clk);
      t++;
    end
    check("read wait released", 32'(wait1), 32'd0);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int snap;
    logic [7:0] sum;
    reset1 = 1'b1; upload1 = 1'b0; rd1 = 1'b0; ack1 = 1'b0; addr1 = '0;
    reset3 = 1'b1; upload3 = 1'b0; rd3 = 1'b0; ack3 = 1'b0; addr3 = '0;
    for (int i = 0; i < 1024; i++) mem[i] = i[7:0];
    mem[5] = 8'hA7;
    repeat (2) @(negedge clk);

    // Reset state
    check("rst din", 32'(din1), 32'h00);
    check("rst wait", 32'(wait1), 32'd0);
    check("rst pause_req", 32'(preq1), 32'd0);
    check("rst ram_addr", 32'(raddr1), 32'd0);
    check("rst ram_rd", 32'(rrd1), 32'd0);
    check("rst busy", 32'(busy1), 32'd0);
    check("rst checksum", 32'(csum1), 32'd0);
    check("rst bytes_sent", 32'(bytes1), 32'd0);
    reset1 = 1'b0; reset3 = 1'b0;
    @(negedge clk);

    // Session start with pause_ack low: stalls, reads ignored
    snap = nrd1;
    upload1 = 1'b1;
    addr1 = 25'd5;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("pause pause_req", 32'(preq1), 32'd1);
      check("pause wait", 32'(wait1), 32'd1);
      rd1 = (i % 3 == 0);
    end
    rd1 = 1'b0;
    ack1 = 1'b1;
    @(negedge clk);
    check("pause ram_rd count", 32'(nrd1 - snap), 32'd0);
    check("ack wait", 32'(wait1), 32'd0);
    check("ack busy", 32'(busy1), 32'd1);

    // Single read of RAM[5]=0xA7
    snap = nrd1;
    read1(25'd5, '{din: 8'hA7, csum: 8'hA7, bytes: 11'd1}, 1);
    check("A7 ram_addr", 32'(raddr1), 32'd5);
    check("A7 ram_rd count", 32'(nrd1 - snap), 32'd1);

    // Second strobe during FETCH is ignored
    snap = nrd1;
    read1(25'd7, '{din: 8'h07, csum: 8'hAE, bytes: 11'd2}, 2);
    check("dbl rd ram_rd count", 32'(nrd1 - snap), 32'd1);

    // End of session: counters and data hold
    upload1 = 1'b0;
    repeat (3) @(negedge clk);
    check("end pause_req", 32'(preq1), 32'd0);
    check("end busy", 32'(busy1), 32'd0);
    check("end checksum", 32'(csum1), 32'hAE);
    check("end bytes_sent", 32'(bytes1), 32'd2);
    check("end din", 32'(din1), 32'h07);

    // Session 2: rd coincident with rising upload is ignored
    mem[5] = 8'h05;
    snap = nrd1;
    upload1 = 1'b1;
    rd1 = 1'b1;
    addr1 = 25'd5;
    @(negedge clk);
    rd1 = 1'b0;
    check("s2 checksum cleared", 32'(csum1), 32'd0);
    check("s2 bytes cleared", 32'(bytes1), 32'd0);
    check("s2 wait", 32'(wait1), 32'd1);
    @(negedge clk);
    check("s2 ready wait", 32'(wait1), 32'd0);
    check("s2 coincident rd ignored", 32'(nrd1 - snap), 32'd0);

    // Full sequential dump
    sum = 8'h00;
    for (int i = 0; i < 1024; i++) begin
      sum = sum + i[7:0];
      read1(25'(i), '{din: i[7:0], csum: sum, bytes: 11'(i + 1)}, 1);
    end
    check("dump checksum", 32'(csum1), 32'h00);
    check("dump bytes_sent", 32'(bytes1), 32'd1024);

    // Out-of-range reads and saturation
    snap = nrd1;
    read1(25'd1024, '{din: 8'hFF, csum: 8'h00, bytes: 11'd1024}, 1);
    read1(25'h100_0000, '{din: 8'hFF, csum: 8'h00, bytes: 11'd1024}, 1);
    check("oor ram_rd count", 32'(nrd1 - snap), 32'd0);
    read1(25'd3, '{din: 8'h03, csum: 8'h03, bytes: 11'd1024}, 1);
    upload1 = 1'b0;
    repeat (3) @(negedge clk);
    check("scoreboard drained", 32'(sb1.size()), 32'd0);

    // RD_LAT=3: full read latency
    upload3 = 1'b1; ack3 = 1'b1;
    repeat (2) @(negedge clk);
    rd3 = 1'b1; addr3 = 25'd2;
    @(negedge clk);
    rd3 = 1'b0;
    check("L3 ram_rd", 32'(rrd3), 32'd1);
    check("L3 ram_addr", 32'(raddr3), 32'd2);
    repeat (3) @(negedge clk);
    check("L3 wait at rd+3", 32'(wait3), 32'd1);
    @(negedge clk);
    check("L3 wait at rd+4", 32'(wait3), 32'd0);
    check("L3 din", 32'(din3), 32'h02);
    check("L3 checksum", 32'(csum3), 32'h02);
    check("L3 bytes_sent", 32'(bytes3), 32'd1);

    // RD_LAT=3: abort one cycle after ioctl_rd
    rd3 = 1'b1; addr3 = 25'd7;
    @(negedge clk);
    rd3 = 1'b0;
    upload3 = 1'b0;
    @(negedge clk);
    check("abort pause_req", 32'(preq3), 32'd0);
    check("abort busy", 32'(busy3), 32'd0);
    check("abort wait", 32'(wait3), 32'd0);
    repeat (4) @(negedge clk);
    check("abort checksum", 32'(csum3), 32'h02);
    check("abort bytes_sent", 32'(bytes3), 32'd1);
    check("abort din", 32'(din3), 32'h02);
    upload3 = 1'b1;
    @(negedge clk);
    check("new session checksum", 32'(csum3), 32'd0);
    check("new session bytes", 32'(bytes3), 32'd0);
    check("new session pause_req", 32'(preq3), 32'd1);
    @(negedge clk);

    // Asynchronous reset while in FETCH
    rd3 = 1'b1; addr3 = 25'd4;
    @(negedge clk);
    rd3 = 1'b0;
    @(posedge clk);
    #2;
    reset3 = 1'b1;
    upload3 = 1'b0;
    #1;
    check("arst din", 32'(din3), 32'h00);
    check("arst wait", 32'(wait3), 32'd0);
    check("arst pause_req", 32'(preq3), 32'd0);
    check("arst ram_addr", 32'(raddr3), 32'd0);
    check("arst ram_rd", 32'(rrd3), 32'd0);
    check("arst busy", 32'(busy3), 32'd0);
    check("arst checksum", 32'(csum3), 32'd0);
    check("arst bytes_sent", 32'(bytes3), 32'd0);
    @(negedge clk);
    reset3 = 1'b0;
    repeat (2) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
